// File: rtl/memory_data_ctx.sv
// Relocating, bounds-checked data memory for the MEM stage: per-context base/limit table,
// range check plus base offset on every access, and a sticky fault capture for the OS.
module memory_data_ctx #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter int NUM_CTX = 4,
    parameter int CTX_W   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ctx_wr_en,
    input  logic [CTX_W-1:0]  ctx_wr_idx,
    input  logic [ADDR_W-1:0] ctx_wr_base,
    input  logic [ADDR_W:0]   ctx_wr_limit,
    input  logic              ctx_sel_en,
    input  logic [CTX_W-1:0]  ctx_sel,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_fault,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr,
    output logic [CTX_W-1:0]  fault_ctx,
    input  logic              fault_clear,
    output logic [CTX_W-1:0]  active_ctx
);

    logic [ADDR_W-1:0] base_tab  [NUM_CTX];
    logic [ADDR_W:0]   limit_tab [NUM_CTX];
    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] cur_base;
    logic [ADDR_W:0]   cur_limit;
    logic [ADDR_W:0]   sum;
    logic [ADDR_W-1:0] phys;
    logic              legal;
    logic              bad;

    // Carry out of the relocation sum is treated as out of range, so there is no wrap-around.
    always_comb begin
        cur_base  = base_tab[active_ctx];
        cur_limit = limit_tab[active_ctx];
        sum       = {1'b0, cur_base} + {1'b0, address};
        phys      = sum[ADDR_W-1:0];
        legal     = ({1'b0, address} < cur_limit) && !sum[ADDR_W];
        bad       = (rd_en || wr_en) && !legal;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            base_tab     <= '{default: '0};
            limit_tab    <= '{default: '0};
            limit_tab[0] <= {1'b1, {ADDR_W{1'b0}}};
            active_ctx   <= '0;
        end else begin
            if (ctx_wr_en) begin
                base_tab[ctx_wr_idx]  <= ctx_wr_base;
                limit_tab[ctx_wr_idx] <= ctx_wr_limit;
            end
            if (ctx_sel_en) begin
                active_ctx <= ctx_sel;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && wr_en && legal) begin
            mem[phys] <= wr_data;
        end
    end

    // The read samples the array before any same-edge store lands, giving read-before-write.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_fault <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_fault <= rd_en && !legal;
            if (rd_en) begin
                rd_data <= legal ? mem[phys] : '0;
            end
        end
    end

    // A new fault wins over a same-cycle clear so it is never lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            fault      <= 1'b0;
            fault_addr <= '0;
            fault_ctx  <= '0;
        end else if (bad && (!fault || fault_clear)) begin
            fault      <= 1'b1;
            fault_addr <= address;
            fault_ctx  <= active_ctx;
        end else if (fault_clear) begin
            fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_data_ctx.sv
// Scoreboard bench for memory_data_ctx: loads push expected responses, a monitor pops and
// compares whenever rd_valid is presented; status outputs are checked directly.
module tb_memory_data_ctx;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 12;
    localparam int NUM_CTX = 4;
    localparam int CTX_W   = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              ctx_wr_en;
    logic [CTX_W-1:0]  ctx_wr_idx;
    logic [ADDR_W-1:0] ctx_wr_base;
    logic [ADDR_W:0]   ctx_wr_limit;
    logic              ctx_sel_en;
    logic [CTX_W-1:0]  ctx_sel;
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_fault;
    logic              fault;
    logic [ADDR_W-1:0] fault_addr;
    logic [CTX_W-1:0]  fault_ctx;
    logic              fault_clear;
    logic [CTX_W-1:0]  active_ctx;

    logic [DATA_W:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    memory_data_ctx #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_CTX(NUM_CTX),
        .CTX_W  (CTX_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ctx_wr_en   (ctx_wr_en),
        .ctx_wr_idx  (ctx_wr_idx),
        .ctx_wr_base (ctx_wr_base),
        .ctx_wr_limit(ctx_wr_limit),
        .ctx_sel_en  (ctx_sel_en),
        .ctx_sel     (ctx_sel),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_fault    (rd_fault),
        .fault       (fault),
        .fault_addr  (fault_addr),
        .fault_ctx   (fault_ctx),
        .fault_clear (fault_clear),
        .active_ctx  (active_ctx)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        ctx_wr_en   = 1'b0;
        ctx_sel_en  = 1'b0;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        fault_clear = 1'b0;
    endtask

    task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        address = a;
        wr_data = d;
        tick();
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic f);
        rd_en   = 1'b1;
        address = a;
        exp_q.push_back({f, d});
        tick();
    endtask

    task automatic program_ctx(input logic [CTX_W-1:0] idx, input logic [ADDR_W-1:0] b,
                               input logic [ADDR_W:0] l);
        ctx_wr_en    = 1'b1;
        ctx_wr_idx   = idx;
        ctx_wr_base  = b;
        ctx_wr_limit = l;
        tick();
    endtask

    task automatic select_ctx(input logic [CTX_W-1:0] c);
        ctx_sel_en = 1'b1;
        ctx_sel    = c;
        tick();
    endtask

    task automatic stimulus();
        reset = 1'b1;
        ctx_wr_en = 1'b0; ctx_wr_idx = '0; ctx_wr_base = '0; ctx_wr_limit = '0;
        ctx_sel_en = 1'b0; ctx_sel = '0; rd_en = 1'b0; wr_en = 1'b0;
        address = '0; wr_data = '0; fault_clear = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_fault", {31'b0, fault}, 32'd0);
        check("reset_fault_addr", {20'b0, fault_addr}, 32'd0);
        check("reset_fault_ctx", {30'b0, fault_ctx}, 32'd0);
        check("reset_active_ctx", {30'b0, active_ctx}, 32'd0);

        // Preload in ctx 0 (full memory, base 0)
        store(12'h010, 32'hDEADBEEF);
        store(12'h500, 32'h55555555);
        store(12'h4FF, 32'h000004FF);
        store(12'h005, 32'hA5A50005);
        store(12'hFFF, 32'h0FFF0FFF);
        store(12'hF10, 32'h0F100F10);
        load(12'h010, 32'hDEADBEEF, 1'b0);
        tick();
        check("idle_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("idle_rd_data_hold", rd_data, 32'hDEADBEEF);

        // Relocation through ctx 1
        program_ctx(2'd1, 12'h400, 13'h100);
        select_ctx(2'd1);
        check("sel_active_ctx1", {30'b0, active_ctx}, 32'd1);
        store(12'h005, 32'h12345678);
        select_ctx(2'd0);
        load(12'h405, 32'h12345678, 1'b0);

        // Select alongside a load: old context (0) is used
        ctx_sel_en = 1'b1;
        ctx_sel    = 2'd1;
        load(12'h005, 32'hA5A50005, 1'b0);
        check("same_cycle_sel_active", {30'b0, active_ctx}, 32'd1);

        // Limit fault
        store(12'h100, 32'hBAD0BAD0);
        check("limit_fault", {31'b0, fault}, 32'd1);
        check("limit_fault_addr", {20'b0, fault_addr}, 32'h100);
        check("limit_fault_ctx", {30'b0, fault_ctx}, 32'd1);
        load(12'h0FF, 32'h000004FF, 1'b0);
        load(12'h200, 32'h0, 1'b1);
        check("sticky_fault_addr", {20'b0, fault_addr}, 32'h100);
        check("sticky_fault_ctx", {30'b0, fault_ctx}, 32'd1);
        select_ctx(2'd0);
        load(12'h500, 32'h55555555, 1'b0);
        fault_clear = 1'b1;
        tick();
        check("cleared_fault", {31'b0, fault}, 32'd0);

        // Carry fault at the top of memory
        program_ctx(2'd2, 12'hF00, 13'h200);
        select_ctx(2'd2);
        load(12'h100, 32'h0, 1'b1);
        check("carry_fault", {31'b0, fault}, 32'd1);
        check("carry_fault_addr", {20'b0, fault_addr}, 32'h100);
        check("carry_fault_ctx", {30'b0, fault_ctx}, 32'd2);
        load(12'h0FF, 32'h0FFF0FFF, 1'b0);

        // Clear together with a new fault: new capture wins
        fault_clear = 1'b1;
        load(12'h1F0, 32'h0, 1'b1);
        check("clear_new_fault", {31'b0, fault}, 32'd1);
        check("clear_new_fault_addr", {20'b0, fault_addr}, 32'h1F0);

        // Store and load together: read-before-write
        wr_en   = 1'b1;
        wr_data = 32'h11112222;
        load(12'h0FF, 32'h0FFF0FFF, 1'b0);
        load(12'h0FF, 32'h11112222, 1'b0);

        // Reset mid-stream, with a load and a store issued in the reset cycle
        load(12'h0FF, 32'h11112222, 1'b0);
        reset   = 1'b1;
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        address = 12'h010;
        wr_data = 32'hFFFFFFFF;
        tick();
        reset = 1'b0;
        check("midreset_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("midreset_active_ctx", {30'b0, active_ctx}, 32'd0);
        check("midreset_fault", {31'b0, fault}, 32'd0);
        check("midreset_fault_addr", {20'b0, fault_addr}, 32'd0);
        load(12'hF10, 32'h0F100F10, 1'b0);
        select_ctx(2'd1);
        load(12'h003, 32'h0, 1'b1);
        check("ctx1_reset_limit_fault", {31'b0, fault}, 32'd1);
        check("ctx1_reset_fault_ctx", {30'b0, fault_ctx}, 32'd1);
        check("ctx1_reset_fault_addr", {20'b0, fault_addr}, 32'h003);
        tick();
        tick();
    endtask

    initial begin
        fork
            stimulus();
            forever begin
                @(negedge clock);
                if (rd_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rd_valid actual=1 required=0");
                    end else begin
                        logic [DATA_W:0] e;
                        e = exp_q.pop_front();
                        check("rd_data", rd_data, e[DATA_W-1:0]);
                        check("rd_fault", {31'b0, rd_fault}, {31'b0, e[DATA_W]});
                    end
                end
            end
            begin
                #200000;
                errors++;
                $display("FAIL timeout actual=running required=done");
            end
        join_any
        check("pending_responses", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
